mux4_1_tdm_scan: RTL and testbench

Time-division 4:1 multiplexer with active-high enable, the gathering counterpart of the 1:4 enable-high demultiplexer. Scans four active-low channel lines in round-robin order, holding each for a fixed dwell, and forwards the selected level on one serial line together with its channel code. Idle level is high on every line, matching the demux idle convention, so a demux on the far end can re-steer `Y` using `S`.

---
 rtl/mux4_tdm_pkg.sv | 11 +
 rtl/rr_next4.sv | 22 ++
 rtl/mux4_1_tdm_scan.sv | 89 ++++++++
 tb/tb_mux4_1_tdm_scan.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mux4_tdm_pkg.sv
// Shared definitions for the 4:1 time-division scan multiplexer.
package mux4_tdm_pkg;
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam int         NUM_CH     = 4;
  localparam logic       IDLE_LEVEL = 1'b1;
  localparam logic [1:0] S_RESET    = 2'd0;
endpackage

// File: rtl/rr_next4.sv
// Circular next-active finder: nearest channel after ptr whose active-low line is 0,
// falling back to ptr+1 when no other channel is active.
module rr_next4
  import mux4_tdm_pkg::*;
(
  input  logic [1:0]        i_ptr,
  input  logic [NUM_CH-1:0] i_d,
  output logic [1:0]        o_next
);
  logic [1:0] w_c1;
  logic [1:0] w_c2;
  logic [1:0] w_c3;

  assign w_c1 = i_ptr + 2'd1;
  assign w_c2 = i_ptr + 2'd2;
  assign w_c3 = i_ptr + 2'd3;

  // Closest candidate wins; the current channel is never considered.
  assign o_next = !i_d[w_c1] ? w_c1 :
                  !i_d[w_c2] ? w_c2 :
                  !i_d[w_c3] ? w_c3 : w_c1;
endmodule

// File: rtl/mux4_1_tdm_scan.sv
// Time-division 4:1 scan multiplexer with per-slot dwell and round-start frame pulse.
// Define MUX4_SKIP_IDLE_EN to jump over channels whose line is idle at each dwell end.
module mux4_1_tdm_scan
  import mux4_tdm_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        E,
  input  logic [3:0]  D,
  output logic        Y,
  output logic [1:0]  S,
  output logic        valid,
  output logic        frame
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  state_t        r_state;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_rstart;
  logic          r_y;
  logic [1:0]    r_s;
  logic          r_valid;
  logic          r_frame;
  logic [1:0]    w_next;

`ifdef MUX4_SKIP_IDLE_EN
  rr_next4 u_next (
    .i_ptr  (r_ptr),
    .i_d    (D),
    .o_next (w_next)
  );
`else
  assign w_next = r_ptr + 2'd1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= S_RESET;
      r_cnt    <= '0;
      r_rstart <= 1'b1;
      r_y      <= IDLE_LEVEL;
      r_s      <= S_RESET;
      r_valid  <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_SCAN: begin
          r_y     <= D[r_ptr];
          r_s     <= r_ptr;
          r_valid <= 1'b1;
          r_frame <= (r_cnt == '0) && r_rstart;
          if (!E) begin
            r_state  <= ST_IDLE;
            r_ptr    <= S_RESET;
            r_cnt    <= '0;
            r_rstart <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            // A slot opens a new round whenever the pointer fails to move forward.
            r_cnt    <= '0;
            r_ptr    <= w_next;
            r_rstart <= (w_next <= r_ptr);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_y      <= IDLE_LEVEL;
          r_s      <= S_RESET;
          r_valid  <= 1'b0;
          r_frame  <= 1'b0;
          r_ptr    <= S_RESET;
          r_cnt    <= '0;
          r_rstart <= 1'b1;
          if (E) r_state <= ST_SCAN;
        end
      endcase
    end
  end

  assign Y     = r_y;
  assign S     = r_s;
  assign valid = r_valid;
  assign frame = r_frame;
endmodule

// File: tb/tb_mux4_1_tdm_scan.sv
// Directed bench for mux4_1_tdm_scan: DWELL=2 and DWELL=1 instances share stimulus.
module tb_mux4_1_tdm_scan;
  logic       clk;
  logic       rst;
  logic       E;
  logic [3:0] D;
  logic       y2, v2, f2, y1, v1, f1;
  logic [1:0] s2, s1;
  int total = 0;
  int bad   = 0;

  mux4_1_tdm_scan #(.DWELL(2)) dut2 (
    .clk(clk), .rst(rst), .E(E), .D(D), .Y(y2), .S(s2), .valid(v2), .frame(f2)
  );
  mux4_1_tdm_scan #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .E(E), .D(D), .Y(y1), .S(s1), .valid(v1), .frame(f1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic start_scan(input logic [3:0] d);
    D = d;
    E = 1'b1;
    tick();
    chk("entry_valid_low", {3'b0, v2}, 4'd0);
    tick();
  endtask

  task automatic stop_scan();
    E = 1'b0;
    tick();
    tick();
    chk("stop_valid", {3'b0, v2}, 4'd0);
    chk("stop_y", {3'b0, y2}, 4'd1);
  endtask

  int ys[8];
  int ss[8];
  int fs[8];
  int ys1[4];
  int ss1[4];
  int fs1[4];

  initial begin
    rst = 1'b1;
    E   = 1'b0;
    D   = 4'hF;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_y", {3'b0, y2}, 4'd1);
    chk("rst_s", {2'b0, s2}, 4'd0);
    chk("rst_valid", {3'b0, v2}, 4'd0);
    chk("rst_frame", {3'b0, f2}, 4'd0);
    chk("rst_valid_d1", {3'b0, v1}, 4'd0);

`ifndef MUX4_SKIP_IDLE_EN
    // DWELL=2, D=0101: Y 1,1,0,0,1,1,0,0 with S 0,0,1,1,2,2,3,3.
    ys = '{1, 1, 0, 0, 1, 1, 0, 0};
    ss = '{0, 0, 1, 1, 2, 2, 3, 3};
    fs = '{1, 0, 0, 0, 0, 0, 0, 0};
    start_scan(4'b0101);
    chk("d0101_valid", {3'b0, v2}, 4'd1);
    for (int i = 0; i < 16; i++) begin
      chk("d0101_y", {3'b0, y2}, 4'(ys[i % 8]));
      chk("d0101_s", {2'b0, s2}, 4'(ss[i % 8]));
      chk("d0101_frame", {3'b0, f2}, 4'(fs[i % 8]));
      tick();
    end
    stop_scan();
`endif

    // DWELL=1, D=1110.
`ifdef MUX4_SKIP_IDLE_EN
    ys1 = '{0, 1, 0, 1};
    ss1 = '{0, 1, 0, 1};
    fs1 = '{1, 0, 1, 0};
`else
    ys1 = '{0, 1, 1, 1};
    ss1 = '{0, 1, 2, 3};
    fs1 = '{1, 0, 0, 0};
`endif
    start_scan(4'b1110);
    for (int i = 0; i < 8; i++) begin
      chk("dw1_y", {3'b0, y1}, 4'(ys1[i % 4]));
      chk("dw1_s", {2'b0, s1}, 4'(ss1[i % 4]));
      chk("dw1_frame", {3'b0, f1}, 4'(fs1[i % 4]));
      chk("dw1_valid", {3'b0, v1}, 4'd1);
      tick();
    end
    stop_scan();

    // DWELL=2, D=0110: channels 0 and 3 active.
`ifdef MUX4_SKIP_IDLE_EN
    ys = '{0, 0, 0, 0, 0, 0, 0, 0};
    ss = '{0, 0, 3, 3, 0, 0, 3, 3};
    fs = '{1, 0, 0, 0, 1, 0, 0, 0};
`else
    ys = '{0, 0, 1, 1, 1, 1, 0, 0};
    ss = '{0, 0, 1, 1, 2, 2, 3, 3};
    fs = '{1, 0, 0, 0, 0, 0, 0, 0};
`endif
    start_scan(4'b0110);
    for (int i = 0; i < 16; i++) begin
      chk("d0110_y", {3'b0, y2}, 4'(ys[i % 8]));
      chk("d0110_s", {2'b0, s2}, 4'(ss[i % 8]));
      chk("d0110_frame", {3'b0, f2}, 4'(fs[i % 8]));
      tick();
    end
    stop_scan();

    // All idle: full rotation in either mode, then drop E during the S=2 slot.
    ss = '{0, 0, 1, 1, 2, 2, 3, 3};
    start_scan(4'b1111);
    for (int i = 0; i < 4; i++) begin
      chk("d1111_s", {2'b0, s2}, 4'(ss[i]));
      chk("d1111_y", {3'b0, y2}, 4'd1);
      tick();
    end
    chk("drop_slot_s", {2'b0, s2}, 4'd2);
    E = 1'b0;
    tick();
    chk("drop_last_valid", {3'b0, v2}, 4'd1);
    chk("drop_last_s", {2'b0, s2}, 4'd2);
    tick();
    chk("drop_valid", {3'b0, v2}, 4'd0);
    chk("drop_y", {3'b0, y2}, 4'd1);
    chk("drop_s", {2'b0, s2}, 4'd0);
    chk("drop_frame", {3'b0, f2}, 4'd0);

    start_scan(4'b0000);
    chk("reen_s", {2'b0, s2}, 4'd0);
    chk("reen_frame", {3'b0, f2}, 4'd1);
    chk("reen_valid", {3'b0, v2}, 4'd1);
    chk("reen_y", {3'b0, y2}, 4'd0);
    tick();
    chk("reen_frame_off", {3'b0, f2}, 4'd0);

    // Reset mid-dwell with E still high.
    rst = 1'b1;
    tick();
    chk("midrst_y", {3'b0, y2}, 4'd1);
    chk("midrst_s", {2'b0, s2}, 4'd0);
    chk("midrst_valid", {3'b0, v2}, 4'd0);
    chk("midrst_frame", {3'b0, f2}, 4'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", {3'b0, v2}, 4'd0);
    tick();
    chk("post_rst_frame", {3'b0, f2}, 4'd1);
    chk("post_rst_s", {2'b0, s2}, 4'd0);
    chk("post_rst_valid2", {3'b0, v2}, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
